// File: rtl/vga_screen_switcher_pkg.sv
// vga_screen_switcher_pkg: shared VGA bus field layout and switcher state encoding
package vga_screen_switcher_pkg;
  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 11;
  localparam int RGB_W = 12;
  localparam int RGB_LSB = 0;
  localparam int VBLNK_BIT = 12;
  localparam int HBLNK_BIT = 13;
  localparam int VSYNC_BIT = 14;
  localparam int HSYNC_BIT = 15;
  localparam int VCOUNT_LSB = 16;
  localparam int HCOUNT_LSB = 27;
  localparam int VGA_BUS_SIZE = HCOUNT_LSB + HCOUNT_W;
  typedef enum logic [1:0] {SHOW = 2'd0, FADE_OUT = 2'd1, FADE_IN = 2'd2} state_t;
endpackage

// File: rtl/vga_screen_switcher_fader.sv
// vga_rgb_fader: scales each 4-bit colour component by level / 2**FADE_SHIFT
module vga_rgb_fader #(
  parameter int FADE_SHIFT = 3
) (
  input  logic [11:0]         rgb,
  input  logic [FADE_SHIFT:0] level,
  output logic [11:0]         rgb_scaled
);
  for (genvar c = 0; c < 3; c++) begin : g_comp
    logic [FADE_SHIFT+4:0] prod;
    assign prod = rgb[c*4 +: 4] * level;
    assign rgb_scaled[c*4 +: 4] = 4'(prod >> FADE_SHIFT);
  end
endmodule

// File: rtl/vga_screen_switcher.sv
// vga_screen_switcher: registered N-channel VGA selector with frame-aligned fade/cut transitions
module vga_screen_switcher import vga_screen_switcher_pkg::*; #(
  parameter int N_CH = 3,
  parameter int CH_W = 2,
  parameter int BUS_W = VGA_BUS_SIZE,
  parameter int DEFAULT_CH = 0,
  parameter bit FADE_EN = 1'b1,
  parameter int FADE_SHIFT = 3
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic [N_CH*BUS_W-1:0] vga_in,
  input  logic [N_CH-1:0]       sel,
  output logic [BUS_W-1:0]      vga_out,
  output logic [CH_W-1:0]       active_ch,
  output logic                  busy
);
  localparam int LVL_MAX_I = 1 << FADE_SHIFT;
  localparam logic [FADE_SHIFT:0] LVL_MAX = LVL_MAX_I[FADE_SHIFT:0];
  state_t state;
  logic [FADE_SHIFT:0] level, lvl_dn, lvl_up;
  logic [CH_W-1:0] req_ch;
  logic [BUS_W-1:0] cur, nxt;
  logic [RGB_W-1:0] rgb_faded;
  logic vblnk_d, fb, want;
  always_comb begin
    req_ch = CH_W'(DEFAULT_CH);
    for (int i = N_CH - 1; i >= 0; i--) req_ch = sel[i] ? CH_W'(i) : req_ch;
  end
  assign cur = vga_in[active_ch*BUS_W +: BUS_W];
  assign fb = cur[VBLNK_BIT] & ~vblnk_d;
  assign want = req_ch != active_ch;
  assign lvl_dn = (level == '0) ? '0 : level - 1'b1;
  assign lvl_up = (level == LVL_MAX) ? LVL_MAX : level + 1'b1;
  assign busy = state != SHOW;
  vga_rgb_fader #(.FADE_SHIFT(FADE_SHIFT)) u_fader (
    .rgb(cur[RGB_LSB +: RGB_W]),
    .level(level),
    .rgb_scaled(rgb_faded)
  );
  // timing fields pass through untouched; only the colour field is replaced
  always_comb begin
    nxt = cur;
    nxt[RGB_LSB +: RGB_W] = rgb_faded;
  end
  always_ff @(posedge pclk or posedge rst)
    if (rst) begin
      state <= SHOW;
      level <= LVL_MAX;
      active_ch <= CH_W'(DEFAULT_CH);
      vblnk_d <= 1'b0;
      vga_out <= '0;
    end else begin
      vga_out <= nxt;
      vblnk_d <= cur[VBLNK_BIT];
      if (fb && want && !FADE_EN) active_ch <= req_ch;
      else if (fb && want) begin
        level <= lvl_dn;
        state <= (lvl_dn == '0) ? FADE_IN : FADE_OUT;
        if (lvl_dn == '0) active_ch <= req_ch;
      end else if (fb && FADE_EN && state != SHOW) begin
        level <= lvl_up;
        state <= (lvl_up == LVL_MAX) ? SHOW : FADE_IN;
      end
    end
endmodule

// File: tb/tb_vga_screen_switcher.sv
// tb_vga_screen_switcher: checks fading and hard-cut switchers against a level/channel reference model
module tb_vga_screen_switcher;
  import vga_screen_switcher_pkg::*;
  localparam int N = 3;
  localparam int BW = VGA_BUS_SIZE;
  localparam int MAXL = 8;
  typedef struct {
    logic [2:0] sel;
    int ch;
  } vec_t;
  logic pclk = 1'b0;
  logic rst;
  logic [N*BW-1:0] vga_in;
  logic [2:0] sel;
  logic [BW-1:0] out_f, out_c;
  logic [1:0] act_f, act_c;
  logic busy_f, busy_c;
  int m_act[2], m_lvl[2];
  bit m_vd[2];
  int fb_cnt, hc, vc, checks, errors;
  logic [11:0] ch_rgb[3];
  bit rnd;
  vec_t tbl[8];
  always #5 pclk = ~pclk;
  vga_screen_switcher #(.FADE_EN(1'b1)) dut (
    .pclk(pclk), .rst(rst), .vga_in(vga_in), .sel(sel),
    .vga_out(out_f), .active_ch(act_f), .busy(busy_f)
  );
  vga_screen_switcher #(.FADE_EN(1'b0)) dut_cut (
    .pclk(pclk), .rst(rst), .vga_in(vga_in), .sel(sel),
    .vga_out(out_c), .active_ch(act_c), .busy(busy_c)
  );
  function automatic logic [BW-1:0] mk(int h, int v, logic [11:0] rgb);
    logic [BW-1:0] b = '0;
    b[HCOUNT_LSB +: HCOUNT_W] = HCOUNT_W'(h);
    b[VCOUNT_LSB +: VCOUNT_W] = VCOUNT_W'(v);
    b[HSYNC_BIT] = h >= 13 && h <= 14;
    b[VSYNC_BIT] = v == 9;
    b[HBLNK_BIT] = h >= 12;
    b[VBLNK_BIT] = v >= 8;
    b[RGB_LSB +: RGB_W] = rgb;
    return b;
  endfunction
  function automatic logic [11:0] scale(logic [11:0] rgb, int lvl);
    logic [11:0] r;
    for (int c = 0; c < 3; c++) r[c*4 +: 4] = 4'((int'(rgb[c*4 +: 4]) * lvl) / MAXL);
    return r;
  endfunction
  function automatic int req_of(logic [2:0] s);
    for (int i = 0; i < N; i++) if (s[i]) return i;
    return 0;
  endfunction
  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic reset_models();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0;
      m_lvl[d] = MAXL;
      m_vd[d] = 1'b0;
    end
  endtask
  // one pixel: drive inputs, predict the registered output, advance the model at the edge
  task automatic cycle();
    logic [BW-1:0] b[3];
    logic [BW-1:0] e[2];
    bit fb[2];
    int r;
    for (int k = 0; k < N; k++) begin
      b[k] = mk(hc, vc, rnd ? 12'($urandom) : ch_rgb[k]);
      vga_in[k*BW +: BW] = b[k];
    end
    for (int d = 0; d < 2; d++) begin
      fb[d] = !rst && b[0][VBLNK_BIT] && !m_vd[d];
      e[d] = b[m_act[d]];
      e[d][RGB_LSB +: RGB_W] = scale(b[m_act[d]][RGB_LSB +: RGB_W], m_lvl[d]);
      if (rst) e[d] = '0;
    end
    @(posedge pclk);
    #1;
    if (rst) reset_models();
    else for (int d = 0; d < 2; d++) begin
      m_vd[d] = b[0][VBLNK_BIT];
      if (fb[d]) begin
        r = req_of(sel);
        if (d == 1) m_act[d] = r;
        else if (r != m_act[d]) begin
          m_lvl[d] = (m_lvl[d] > 0) ? m_lvl[d] - 1 : 0;
          if (m_lvl[d] == 0) m_act[d] = r;
        end else m_lvl[d] = (m_lvl[d] < MAXL) ? m_lvl[d] + 1 : MAXL;
      end
    end
    if (fb[0]) fb_cnt++;
    chk("vga_out_fade", out_f, e[0]);
    chk("active_fade", act_f, m_act[0]);
    chk("busy_fade", busy_f, m_lvl[0] < MAXL);
    chk("vga_out_cut", out_c, e[1]);
    chk("active_cut", act_c, m_act[1]);
    chk("busy_cut", busy_c, 0);
    hc = (hc == 15) ? 0 : hc + 1;
    if (hc == 0) vc = (vc == 9) ? 0 : vc + 1;
  endtask
  task automatic run(int n);
    repeat (n) cycle();
  endtask
  task automatic wait_fb(int n);
    int target = fb_cnt + n;
    int budget = n * 200;
    while (fb_cnt < target && budget > 0) begin
      cycle();
      budget--;
    end
    if (fb_cnt < target) chk("fb_timeout", fb_cnt, target);
  endtask
  task automatic run_until_vc(int v);
    int budget = 200;
    while (vc != v && budget > 0) begin
      cycle();
      budget--;
    end
  endtask
  initial begin
    tbl[0] = '{3'b110, 1};
    tbl[1] = '{3'b000, 0};
    tbl[2] = '{3'b100, 2};
    tbl[3] = '{3'b011, 0};
    tbl[4] = '{3'b010, 1};
    tbl[5] = '{3'b111, 0};
    tbl[6] = '{3'b100, 2};
    tbl[7] = '{3'b101, 0};
    checks = 0;
    errors = 0;
    fb_cnt = 0;
    hc = 0;
    vc = 0;
    rnd = 1'b1;
    ch_rgb[0] = 12'hFFF;
    ch_rgb[1] = 12'h123;
    ch_rgb[2] = 12'hABC;
    vga_in = '0;
    sel = 3'b000;
    rst = 1'b1;
    reset_models();
    run(2);
    chk("rst_vga_out", out_f, 0);
    chk("rst_active", act_f, 0);
    chk("rst_busy", busy_f, 0);
    rst = 1'b0;
    run(200);
    // full fade from ch0 to ch2 with a request made mid-line
    rnd = 1'b0;
    run_until_vc(3);
    run(5);
    sel = 3'b100;
    run_until_vc(7);
    chk("pre_fb_active", act_f, 0);
    chk("pre_fb_busy", busy_f, 0);
    wait_fb(1);
    chk("fb1_busy", busy_f, 1);
    chk("fb1_active", act_f, 0);
    chk("cut_switch", act_c, 2);
    cycle();
    chk("fb1_rgb", out_f[RGB_LSB +: RGB_W], 12'hDDD);
    chk("cut_rgb_unscaled", out_c[RGB_LSB +: RGB_W], 12'hABC);
    wait_fb(3);
    cycle();
    chk("fb4_rgb", out_f[RGB_LSB +: RGB_W], 12'h777);
    wait_fb(4);
    chk("fb8_active", act_f, 2);
    chk("fb8_busy", busy_f, 1);
    wait_fb(8);
    chk("fb16_busy", busy_f, 0);
    chk("fb16_active", act_f, 2);
    // priority resolution seen through the hard-cut switcher
    for (int i = 0; i < 8; i++) begin
      sel = tbl[i].sel;
      wait_fb(1);
      chk($sformatf("prio_%0d", i), act_c, tbl[i].ch);
    end
    sel = 3'b000;
    wait_fb(16);
    chk("settle_busy", busy_f, 0);
    chk("settle_active", act_f, 0);
    // withdrawn request reverses the fade at level 5
    sel = 3'b100;
    wait_fb(3);
    cycle();
    chk("rev_rgb", out_f[RGB_LSB +: RGB_W], 12'h999);
    sel = 3'b000;
    wait_fb(2);
    chk("rev_busy2", busy_f, 1);
    wait_fb(1);
    chk("rev_busy3", busy_f, 0);
    chk("rev_active", act_f, 0);
    // reset in the middle of a fade-out
    sel = 3'b100;
    wait_fb(4);
    cycle();
    chk("mid_busy", busy_f, 1);
    chk("mid_rgb", out_f[RGB_LSB +: RGB_W], 12'h777);
    rst = 1'b1;
    #1;
    chk("arst_vga_out", out_f, 0);
    chk("arst_active", act_f, 0);
    chk("arst_busy", busy_f, 0);
    chk("arst_cut_active", act_c, 0);
    reset_models();
    cycle();
    rst = 1'b0;
    sel = 3'b000;
    run(320);
    chk("post_rst_busy", busy_f, 0);
    chk("post_rst_active", act_f, 0);
    // random requests and pixel data against the model
    rnd = 1'b1;
    repeat (30) begin
      sel = 3'($urandom);
      run($urandom_range(20, 400));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
